// File: rtl/wb_stage_if.sv
// Bundle between the memory stage and the writeback stage, plus the
// register-file write port and the forwarding tap driven by writeback.
interface wb_stage_if #(
  parameter int XLEN = 32
);
  // in_valid/in_ready: a transfer happens on a rising edge where both are 1;
  // in_ready may depend combinationally on mem_rvalid, in_valid never on in_ready.
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic            in_reg_write;
  logic [1:0]      in_wb_sel;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc_plus4;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;

  modport master (
    output in_valid, in_rd, in_reg_write, in_wb_sel, in_funct3,
           in_alu_result, in_pc_plus4, mem_rvalid, mem_rdata,
    input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data
  );

  modport slave (
    input  in_valid, in_rd, in_reg_write, in_wb_sel, in_funct3,
           in_alu_result, in_pc_plus4, mem_rvalid, mem_rdata,
    output in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data
  );
endinterface

// File: rtl/wb_stage.sv
// RISC-V writeback stage: holds one retiring instruction, extends load data,
// drives the register-file write port, counts retirements and flags load errors.
module wb_stage #(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  wb_stage_if.slave   bus,
  output logic [63:0] instret,
  output logic        err_misalign,
  output logic        err_timeout,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD  = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d;
  logic [1:0]      sel_q, sel_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [63:0]     instret_q, instret_d;
  logic            mis_q, mis_d;
  logic            to_q, to_d;

  logic            retire_data, timeout, retire, accept, we, misaligned;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] load_data, result;

  // Lane selection and extension of the raw memory word for the held load.
  always_comb begin
    lane_b = 8'h00;
    case (alu_q[1:0])
      2'd0:    lane_b = bus.mem_rdata[7:0];
      2'd1:    lane_b = bus.mem_rdata[15:8];
      2'd2:    lane_b = bus.mem_rdata[23:16];
      default: lane_b = bus.mem_rdata[31:24];
    endcase
    lane_h = alu_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_data = {24'h0, lane_b};
      3'b101:  load_data = {16'h0, lane_h};
      default: load_data = bus.mem_rdata;
    endcase
    case (f3_q)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = alu_q[0];
      default:        misaligned = (alu_q[1:0] != 2'b00);
    endcase
    case (sel_q)
      2'b01:   result = load_data;
      2'b10:   result = pc4_q;
      default: result = alu_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    rw_d        = rw_q;
    sel_d       = sel_q;
    f3_d        = f3_q;
    alu_d       = alu_q;
    pc4_d       = pc4_q;
    instret_d   = instret_q;
    mis_d       = mis_q;
    to_d        = to_q;
    retire_data = 1'b0;
    timeout     = 1'b0;

    case (state_q)
      S_HOLD: retire_data = 1'b1;
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          retire_data = 1'b1;
        end else if (cnt_q == CW'(LOAD_TIMEOUT - 1)) begin
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase

    retire = retire_data | timeout;
    accept = bus.in_valid & ((state_q == S_EMPTY) | retire);
    we     = retire_data & rw_q & (rd_q != 5'd0);

    if (retire) begin
      state_d   = S_EMPTY;
      cnt_d     = '0;
      instret_d = instret_q + 64'd1;
    end
    if (retire_data && state_q == S_WAIT && misaligned) mis_d = 1'b1;
    if (timeout) to_d = 1'b1;

    if (accept) begin
      rd_d    = bus.in_rd;
      rw_d    = bus.in_reg_write;
      sel_d   = bus.in_wb_sel;
      f3_d    = bus.in_funct3;
      alu_d   = bus.in_alu_result;
      pc4_d   = bus.in_pc_plus4;
      state_d = (bus.in_wb_sel == 2'b01) ? S_WAIT : S_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_EMPTY;
      cnt_q     <= '0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      sel_q     <= '0;
      f3_q      <= '0;
      alu_q     <= '0;
      pc4_q     <= '0;
      instret_q <= '0;
      mis_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      sel_q     <= sel_d;
      f3_q      <= f3_d;
      alu_q     <= alu_d;
      pc4_q     <= pc4_d;
      instret_q <= instret_d;
      mis_q     <= mis_d;
      to_q      <= to_d;
    end
  end

  assign bus.in_ready  = (state_q == S_EMPTY) | retire;
  assign bus.rf_we     = we;
  assign bus.rf_waddr  = we ? rd_q : 5'd0;
  assign bus.rf_wdata  = we ? result : '0;
  assign bus.fwd_valid = bus.rf_we;
  assign bus.fwd_rd    = bus.rf_waddr;
  assign bus.fwd_data  = bus.rf_wdata;
  assign instret       = instret_q;
  assign err_misalign  = mis_q;
  assign err_timeout   = to_q;
  assign dbg_state     = state_q;

endmodule
